datactrl: RTL

- Data-memory responder for the out-of-order core.
- Serves load requests from the load buffer and committed-store requests from the store buffer.
- Performs little-endian byte-serial accesses on the 8-bit data-side RAM port.
- Returns sign- or zero-extended load results and store acknowledges as one-cycle pulses. The instruction-fetch/data mux is outside this block.

---
 rtl/datactrl_pkg.sv | 39 +++
 rtl/datactrl_extend.sv | 22 ++
 rtl/datactrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/datactrl_pkg.sv
// Shared constants and types for the data-memory responder.
// Holds the default widths, the one-hot access-width encodings, the FSM state type
// and the width decoder. Build option DATACTRL_IO_STALL_EN adds the I/O store addresses.
package datactrl_pkg;

  localparam int DC_ADDR_W = 32;
  localparam int DC_DATA_W = 32;

  // One-hot byte-count encodings as sent by the load and store buffers.
  localparam logic [2:0] WIDTH_B = 3'b001;
  localparam logic [2:0] WIDTH_H = 3'b010;
  localparam logic [2:0] WIDTH_W = 3'b100;

`ifdef DATACTRL_IO_STALL_EN
  // Memory-mapped I/O locations whose stores must wait for room in the I/O buffer.
  localparam logic [31:0] IO_ADDR_0 = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR_1 = 32'h0003_0004;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2,
    ST_RESP  = 2'd3
  } dc_state_t;

  // Decode the one-hot width into a byte count; malformed encodings mean a full word.
  function automatic logic [2:0] width_bytes(input logic [2:0] width);
    logic [2:0] n;
    case (width)
      WIDTH_B: n = 3'd1;
      WIDTH_H: n = 3'd2;
      WIDTH_W: n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/datactrl_extend.sv
// Load-result extender: widens a 1/2/4-byte little-endian value to a full word.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: i_word (assembled bytes), i_nbytes (1, 2 or 4), i_sgn (sign-extend), o_word.
module datactrl_extend #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [2:0]        i_nbytes,
  input  logic              i_sgn,
  output logic [DATA_W-1:0] o_word
);

  always_comb begin
    o_word = i_word;
    case (i_nbytes)
      3'd1:    o_word = {{(DATA_W-8){i_sgn & i_word[7]}}, i_word[7:0]};
      3'd2:    o_word = {{(DATA_W-16){i_sgn & i_word[15]}}, i_word[15:0]};
      default: o_word = i_word;
    endcase
  end

endmodule

// File: rtl/datactrl.sv
// Data-memory responder: serves loads and committed stores over a byte-serial RAM port.
// Latency: load pulse w+1 cycles after accept, store ack w cycles after accept (w = bytes).
// Backpressure: requests are levels sampled only in IDLE; rdy_in low freezes everything.
// Ports: load-buffer request/response, store-buffer request/ack, ROB flush, 8-bit RAM port
// (mem_a/mem_dout/mem_wr out, mem_din in, read data valid one cycle after address).
// Build option DATACTRL_IO_STALL_EN adds io_buffer_full_in, which holds off I/O stores.
module datactrl
  import datactrl_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int DATA_W = DC_DATA_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_datactrl_rst_in,
  input  logic              lbuffer_datactrl_en_in,
  input  logic [ADDR_W-1:0] lbuffer_datactrl_addr_in,
  input  logic [2:0]        lbuffer_datactrl_width_in,
  input  logic              lbuffer_datactrl_sgn_in,
  output logic              datactrl_lbuffer_en_out,
  output logic [DATA_W-1:0] datactrl_lbuffer_data_out,
  input  logic              sbuffer_datactrl_en_in,
  input  logic [ADDR_W-1:0] sbuffer_datactrl_addr_in,
  input  logic [2:0]        sbuffer_datactrl_width_in,
  input  logic [DATA_W-1:0] sbuffer_datactrl_data_in,
  output logic              datactrl_sbuffer_en_out,
`ifdef DATACTRL_IO_STALL_EN
  input  logic              io_buffer_full_in,
`endif
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  localparam int NBYTES = DATA_W / 8;

  dc_state_t         r_state;
  logic [2:0]        r_cnt;
  logic [2:0]        r_nbytes;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sdata;
  logic              r_sgn;
  logic              r_is_load;
  logic [DATA_W-1:0] r_asm;
  logic [DATA_W-1:0] r_ldout;

  dc_state_t         w_state_nxt;
  logic [2:0]        w_cnt_nxt;
  logic              w_acc_st;
  logic              w_acc_ld;
  logic              w_ld_done;
  logic              w_st_blocked;
  logic [DATA_W-1:0] w_asm_nxt;
  logic [DATA_W-1:0] w_ext;

`ifdef DATACTRL_IO_STALL_EN
  assign w_st_blocked = io_buffer_full_in &&
                        ((sbuffer_datactrl_addr_in == ADDR_W'(IO_ADDR_0)) ||
                         (sbuffer_datactrl_addr_in == ADDR_W'(IO_ADDR_1)));
`else
  assign w_st_blocked = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_st    = 1'b0;
    w_acc_ld    = 1'b0;
    w_ld_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        // Committed stores win over loads; a flush in the same edge only vetoes the load.
        if (sbuffer_datactrl_en_in && !w_st_blocked) begin
          w_state_nxt = ST_STORE;
          w_acc_st    = 1'b1;
        end else if (lbuffer_datactrl_en_in && !rob_datactrl_rst_in) begin
          w_state_nxt = ST_LOAD;
          w_acc_ld    = 1'b1;
        end
      end
      ST_LOAD: begin
        // r_cnt runs 0..w: addresses go out for 0..w-1, byte r_cnt-1 arrives for 1..w.
        if (rob_datactrl_rst_in) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == r_nbytes) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = '0;
          w_ld_done   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ST_STORE: begin
        // Stores are already committed, so a flush does not interrupt them.
        if (r_cnt == r_nbytes - 3'd1) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_asm_nxt = r_asm;
    if (r_state == ST_LOAD) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (r_cnt == 3'(b + 1)) w_asm_nxt[8*b +: 8] = mem_din;
      end
    end

    mem_a    = '0;
    mem_dout = '0;
    if ((r_state == ST_LOAD && r_cnt < r_nbytes) || r_state == ST_STORE) begin
      mem_a = r_addr + ADDR_W'(r_cnt);
    end
    if (r_state == ST_STORE) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (r_cnt == 3'(b)) mem_dout = r_sdata[8*b +: 8];
      end
    end
    mem_wr = (r_state == ST_STORE) && rdy_in;

    // Pulses are qualified by rdy_in so a freeze in RESP cannot stretch them, and a flush
    // arriving during a load response kills the pulse in that same cycle.
    datactrl_lbuffer_en_out = (r_state == ST_RESP) && r_is_load && rdy_in &&
                              !rob_datactrl_rst_in;
    datactrl_sbuffer_en_out = (r_state == ST_RESP) && !r_is_load && rdy_in;
  end

  // Extend the word including the byte arriving this cycle so the result is ready at RESP.
  datactrl_extend #(
    .DATA_W (DATA_W)
  ) u_extend (
    .i_word   (w_asm_nxt),
    .i_nbytes (r_nbytes),
    .i_sgn    (r_sgn),
    .o_word   (w_ext)
  );

  assign datactrl_lbuffer_data_out = r_ldout;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_nbytes  <= '0;
      r_addr    <= '0;
      r_sdata   <= '0;
      r_sgn     <= 1'b0;
      r_is_load <= 1'b0;
      r_asm     <= '0;
      r_ldout   <= '0;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_acc_st) begin
        r_addr    <= sbuffer_datactrl_addr_in;
        r_nbytes  <= width_bytes(sbuffer_datactrl_width_in);
        r_sdata   <= sbuffer_datactrl_data_in;
        r_is_load <= 1'b0;
      end else if (w_acc_ld) begin
        r_addr    <= lbuffer_datactrl_addr_in;
        r_nbytes  <= width_bytes(lbuffer_datactrl_width_in);
        r_sgn     <= lbuffer_datactrl_sgn_in;
        r_is_load <= 1'b1;
        r_asm     <= '0;
      end else if (r_state == ST_LOAD && !rob_datactrl_rst_in) begin
        r_asm <= w_asm_nxt;
      end
      // Only a completed, unflushed load updates the visible result.
      if (w_ld_done) r_ldout <= w_ext;
    end
  end

endmodule
